// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : simple_processor_pkg
// Description : Shared datapath width and 2-bit ALU function codes for the
//               simple processor datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] FUNC_AND = 2'b00;
    localparam logic [1:0] FUNC_OR  = 2'b01;
    localparam logic [1:0] FUNC_XOR = 2'b10;
    localparam logic [1:0] FUNC_NOT = 2'b11;

endpackage : simple_processor_pkg
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_operand_stage_if
// Description : Bundles the instruction handshake, the operand/result path to
//               the ALU gate, the register preload port and the retire
//               counter of alu_operand_stage.
//   slave  modport : the operand stage itself
//   master modport : upstream issue logic / downstream ALU side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 3
);
    // Upstream instruction handshake
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [1:0]            func_i;
    logic [AW-1:0]         rd_addr_i;
    logic [AW-1:0]         rs1_addr_i;
    logic [AW-1:0]         rs2_addr_i;

    // Downstream operand/result handshake
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] rs1_data_o;
    logic [DATA_WIDTH-1:0] rs2_data_o;
    logic [1:0]            func_o;
    logic [AW-1:0]         rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;

    // Register preload port
    logic                  ld_en_i;
    logic [AW-1:0]         ld_addr_i;
    logic [DATA_WIDTH-1:0] ld_data_i;

    // Statistics
    logic [15:0]           retire_cnt_o;

    modport slave (
        input  instr_valid_i, func_i, rd_addr_i, rs1_addr_i, rs2_addr_i,
        input  out_ready_i, rd_data_i,
        input  ld_en_i, ld_addr_i, ld_data_i,
        output instr_ready_o, out_valid_o, rs1_data_o, rs2_data_o,
        output func_o, rd_addr_o, retire_cnt_o
    );

    modport master (
        output instr_valid_i, func_i, rd_addr_i, rs1_addr_i, rs2_addr_i,
        output out_ready_i, rd_data_i,
        output ld_en_i, ld_addr_i, ld_data_i,
        input  instr_ready_o, out_valid_o, rs1_data_o, rs2_data_o,
        input  func_o, rd_addr_o, retire_cnt_o
    );

endinterface : alu_operand_stage_if
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Register file plus one-deep operand register feeding a
//               combinational ALU gate. An accepted instruction has its
//               operands read (with forwarding of the retiring result) and
//               presented one cycle later; on retire the ALU result is written
//               back to the destination register.
// Ports       :
//   clk_i    - clock, rising edge
//   arst_ni  - asynchronous active-low reset
//   bus      - alu_operand_stage_if.slave: instruction handshake, operand /
//              result handshake, register preload port, retire counter
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import simple_processor_pkg::*;
#(
    parameter int NUM_REGS = 8
)(
    input  logic               clk_i,
    input  logic               arst_ni,
    alu_operand_stage_if.slave bus
);

    localparam int AW = $clog2(NUM_REGS);

    typedef logic [DATA_WIDTH-1:0] word_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    word_t         rf_q [NUM_REGS];
    word_t         rf_d [NUM_REGS];

    logic          valid_q,    valid_d;
    word_t         rs1_q,      rs1_d;
    word_t         rs2_q,      rs2_d;
    logic [1:0]    func_q,     func_d;
    logic [AW-1:0] rd_addr_q,  rd_addr_d;
    logic [15:0]   cnt_q,      cnt_d;

    logic          w_ready;
    logic          w_accept;
    logic          w_retire;
    word_t         w_rs1;
    word_t         w_rs2;

    // ------------------------------------------------------------------
    // Handshake: a retiring instruction frees the slot in the same cycle
    // ------------------------------------------------------------------
    assign w_ready  = !valid_q || bus.out_ready_i;
    assign w_accept = bus.instr_valid_i && w_ready;
    assign w_retire = valid_q && bus.out_ready_i;

    // ------------------------------------------------------------------
    // Operand read. The result being written back this cycle is forwarded
    // so the new instruction never sees the stale entry. Preload data is
    // deliberately not forwarded. Register 0 always reads zero, which also
    // masks any forwarding of a result targeted at register 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1 = '0;
        if (bus.rs1_addr_i != '0) begin
            if (w_retire && (bus.rs1_addr_i == rd_addr_q)) begin
                w_rs1 = bus.rd_data_i;
            end else begin
                w_rs1 = rf_q[bus.rs1_addr_i];
            end
        end
    end

    always_comb begin
        w_rs2 = '0;
        if (bus.rs2_addr_i != '0) begin
            if (w_retire && (bus.rs2_addr_i == rd_addr_q)) begin
                w_rs2 = bus.rd_data_i;
            end else begin
                w_rs2 = rf_q[bus.rs2_addr_i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file next state. Retire writeback has priority over a
    // preload to the same index; entry 0 is never written.
    // ------------------------------------------------------------------
    always_comb begin
        rf_d    = rf_q;
        rf_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_retire && (rd_addr_q == AW'(i))) begin
                rf_d[i] = bus.rd_data_i;
            end else if (bus.ld_en_i && (bus.ld_addr_i == AW'(i))) begin
                rf_d[i] = bus.ld_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand register next state. Without accept or retire everything
    // holds, which keeps the outputs stable under back-pressure.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        func_d    = func_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;

        if (w_accept) begin
            valid_d   = 1'b1;
            rs1_d     = w_rs1;
            rs2_d     = w_rs2;
            func_d    = bus.func_i;
            rd_addr_d = bus.rd_addr_i;
        end else if (w_retire) begin
            valid_d   = 1'b0;
        end

        // 16-bit counter wraps naturally from 0xFFFF to 0x0000
        if (w_retire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            valid_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            func_q    <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            rf_q      <= rf_d;
            valid_q   <= valid_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            func_q    <= func_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.instr_ready_o = w_ready;
    assign bus.out_valid_o   = valid_q;
    assign bus.rs1_data_o    = rs1_q;
    assign bus.rs2_data_o    = rs2_q;
    assign bus.func_o        = func_q;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.retire_cnt_o  = cnt_q;

endmodule : alu_operand_stage
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL import simple_processor_pkg and take DATA_WIDTH and the 2-bit function codes AND, OR, XOR, NOT from it.
REQ-002 Parameter NUM_REGS, default 8, SHALL set the register count (power of two, at least 2); AW = $clog2(NUM_REGS).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 arst_ni  in  1  asynchronous active-low reset.
REQ-006 instr_valid_i  in  1  upstream instruction valid.
REQ-007 instr_ready_o  out  1  stage can accept an instruction.
REQ-008 func_i  in  2  ALU function code.
REQ-009 rd_addr_i / rs1_addr_i / rs2_addr_i  in  AW each  destination and source register indices.
REQ-010 out_valid_o  out  1  operands presented to the ALU gate are valid.
REQ-011 out_ready_i  in  1  downstream accepts the operands and result this cycle.
REQ-012 rs1_data_o / rs2_data_o  out  DATA_WIDTH each  registered operands to the ALU gate.
REQ-013 func_o  out  2  registered function code to the ALU gate.
REQ-014 rd_addr_o  out  AW  registered destination index.
REQ-015 rd_data_i  in  DATA_WIDTH  combinational ALU result for the held operands.
REQ-016 ld_en_i / ld_addr_i / ld_data_i  in  1 / AW / DATA_WIDTH  register preload port.
REQ-017 retire_cnt_o  out  16  count of retired instructions.

Function
REQ-018 The register file SHALL hold NUM_REGS x DATA_WIDTH entries; register 0 SHALL always read 0 and ignore all writes.
REQ-019 Accept: instr_valid_i && instr_ready_o; instr_ready_o = !out_valid_o || out_ready_i (combinational, no bubble).
REQ-020 On accept, the block SHALL register func_i, rd_addr_i and the operands read at rs1_addr_i and rs2_addr_i, and set out_valid_o the next cycle (latency 1).
REQ-021 Retire: out_valid_o && out_ready_i; on retire, rd_data_i SHALL be written to regfile[rd_addr_o] at that edge.
REQ-022 Retire without a same-cycle accept SHALL clear out_valid_o.
REQ-023 While out_valid_o && !out_ready_i, all output registers SHALL hold stable.
REQ-024 Forwarding: on a same-cycle retire and accept, a source index equal to rd_addr_o (nonzero) SHALL capture rd_data_i, not the stale entry.
REQ-025 A ld_en_i write SHALL take effect at the edge; on the same index as a retire write, the retire write SHALL win.
REQ-026 Load data SHALL NOT be forwarded; an operand read in the load cycle sees the old value.
REQ-027 The preload port SHALL operate regardless of handshake state.
REQ-028 retire_cnt_o SHALL increment by 1 per retire and wrap 0xFFFF -> 0x0000.
REQ-029 func_o SHALL pass the code unchanged; the stage performs no function decoding.

Reset
REQ-030 While arst_ni = 0: out_valid_o = 0, rs1_data_o = rs2_data_o = 0, func_o = 0, rd_addr_o = 0, retire_cnt_o = 0, all registers = 0.
REQ-031 instr_ready_o SHALL be 1 during and after reset.
REQ-032 Reset asserted mid-operation SHALL discard the held instruction without writeback.
REQ-033 The first accept SHALL be possible on the first rising edge after deassertion.

Verification
REQ-034 Preload r1 = 0x0000_00F0 and r2 = 0x0000_0FF0, then issue AND rd=3, rs1=1, rs2=2 -> next cycle rs1_data_o = 0xF0, rs2_data_o = 0xFF0, func_o = AND, out_valid_o = 1.
REQ-035 Back-to-back with out_ready_i = 1: retire rd=3 with rd_data_i = 0x55 while accepting rs1 = 3 -> rs1_data_o = 0x55 (forwarded); retire_cnt_o = 2 after both retire.
REQ-036 Hold out_ready_i = 0 for 3 cycles with instr_valid_i = 1 -> instr_ready_o = 0, outputs stable, no regfile write, retire_cnt_o unchanged.
REQ-037 NOT rd=0 with rd_data_i = 0xFFFF_FFFF, then read rs1 = 0 -> operand 0; same-cycle load and retire to r5 -> r5 holds the retire data.
REQ-038 Preset retire_cnt_o to 0xFFFF by 65535 retires, retire once more -> 0x0000; assert arst_ni low with out_valid_o = 1 -> all outputs 0, target register unchanged.
